// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared widths, types and reset-value helper for the LEGv8
//               32 x 64-bit integer register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int XLEN   = 64;
    localparam int NREGS  = 32;
    localparam int AW     = $clog2(NREGS);
    // X31 (XZR) has no storage, so only NREGS-1 physical registers exist.
    localparam int NSTORE = NREGS - 1;

    typedef logic [AW-1:0]   reg_idx_t;
    typedef logic [XLEN-1:0] xword_t;

    localparam reg_idx_t ZERO_REG = 5'd31;

    function automatic xword_t reset_value(input int idx);
        return xword_t'(idx);
    endfunction

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/regfile_rdport.sv
// ============================================================================
// Module      : regfile_rdport
// Description : One combinational read port of the register file. Index 31
//               always reads zero. Write-first forwarding is compiled in when
//               REGFILE_BYPASS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_rdport
    import regfile_pkg::*;
(
    input  logic [AW-1:0]   i_ra,
    input  logic [XLEN-1:0] i_regs [NSTORE],
    input  logic            i_byp_vld,
    input  logic [AW-1:0]   i_byp_addr,
    input  logic [XLEN-1:0] i_byp_data,
    output logic [XLEN-1:0] o_rd
);

    xword_t w_stored;

    // Index 31 matches no loop iteration and falls through to the zero default.
    always_comb begin
        w_stored = '0;
        for (int i = 0; i < NSTORE; i++) begin
            if (i_ra == reg_idx_t'(i)) begin
                w_stored = i_regs[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic w_byp_hit;

    // i_byp_vld is already qualified against ZERO_REG by the write decode.
    assign w_byp_hit = i_byp_vld && (i_byp_addr == i_ra);
    assign o_rd      = w_byp_hit ? i_byp_data : w_stored;
`else
    logic w_unused_byp;

    assign w_unused_byp = ^{i_byp_vld, i_byp_addr, i_byp_data};
    assign o_rd         = w_stored;
`endif

endmodule : regfile_rdport

`default_nettype wire

// File: rtl/regfile.sv
// ============================================================================
// Module      : regfile
// Description : LEGv8 64-bit, 32-entry register file, 2 combinational read
//               ports and 1 clocked write port; X31 is hard-wired zero.
//               Optional write-first forwarding: define REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile
    import regfile_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            we3,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    input  logic [AW-1:0]   wa3,
    input  logic [XLEN-1:0] wd3,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    xword_t r_regs [NSTORE];
    logic   w_wr_vld;

    // Writes aimed at XZR are discarded here so neither storage nor bypass sees them.
    assign w_wr_vld = we3 && (wa3 != ZERO_REG);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NSTORE; i++) begin
                r_regs[i] <= reset_value(i);
            end
        end else if (w_wr_vld) begin
            for (int i = 0; i < NSTORE; i++) begin
                if (wa3 == reg_idx_t'(i)) begin
                    r_regs[i] <= wd3;
                end
            end
        end
    end

    regfile_rdport u_rdport1 (
        .i_ra       (ra1),
        .i_regs     (r_regs),
        .i_byp_vld  (w_wr_vld),
        .i_byp_addr (wa3),
        .i_byp_data (wd3),
        .o_rd       (rd1)
    );

    regfile_rdport u_rdport2 (
        .i_ra       (ra2),
        .i_regs     (r_regs),
        .i_byp_vld  (w_wr_vld),
        .i_byp_addr (wa3),
        .i_byp_data (wd3),
        .o_rd       (rd2)
    );

endmodule : regfile

`default_nettype wire

// File: tb/tb_regfile.sv
// ============================================================================
// Module      : tb_regfile
// Description : Self-checking bench for regfile against an array-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        we3;
    logic [4:0]  ra1, ra2, wa3;
    logic [63:0] wd3;
    logic [63:0] rd1, rd2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] model [32];

    regfile dut (
        .clk   (clk),
        .reset (reset),
        .we3   (we3),
        .ra1   (ra1),
        .ra2   (ra2),
        .wa3   (wa3),
        .wd3   (wd3),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] m_read(input logic [4:0] a);
        return (a == 5'd31) ? 64'd0 : model[a];
    endfunction

    // Expected combinational read given the inputs currently driven.
    function automatic logic [63:0] m_read_now(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
        if (we3 && wa3 != 5'd31 && a == wa3) return wd3;
`endif
        return m_read(a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = (i == 31) ? 64'd0 : 64'(i);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [63:0] d, input logic en);
        @(negedge clk);
        we3 = en; wa3 = a; wd3 = d;
        @(posedge clk);
        if (en && a != 5'd31) model[a] = d;
        @(negedge clk);
        we3 = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; we3 = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 32; a++) begin
            logic [63:0] exp_v;
            exp_v = (a == 31) ? 64'd0 : 64'(a);
            ra1 = 5'(a); ra2 = 5'(a);
            #1;
            n_tests++;
            if (rd1 !== exp_v || rd2 !== exp_v) begin
                n_fail++;
                $display("FAIL reset_sweep idx=%0d rd1=%h rd2=%h expected=%h", a, rd1, rd2, exp_v);
            end
        end
    endtask

    task automatic test_write_all();
        logic [4:0] addrs [8];
        addrs = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd7, 5'd31};
        for (int k = 0; k < 8; k++) do_write(addrs[k], 64'd32, 1'b1);
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a); ra2 = 5'(31 - a);
            #1;
            n_tests++;
            if (rd1 !== m_read(ra1) || rd2 !== m_read(ra2)) begin
                n_fail++;
                $display("FAIL write_all ra1=%0d rd1=%h exp=%h ra2=%0d rd2=%h exp=%h",
                         ra1, rd1, m_read(ra1), ra2, rd2, m_read(ra2));
            end
        end
        ra1 = 5'd6; ra2 = 5'd31;
        #1;
        n_tests++;
        if (rd1 !== 64'd6 || rd2 !== 64'd0) begin
            n_fail++;
            $display("FAIL write_all_untouched X6=%h exp=6 X31=%h exp=0", rd1, rd2);
        end
    endtask

    task automatic test_write_disable();
        do_write(5'd10, 64'hDEADBEEF_CAFEF00D, 1'b0);
        ra1 = 5'd10;
        #1;
        n_tests++;
        if (rd1 !== 64'd10) begin
            n_fail++;
            $display("FAIL write_disable rd1=%h expected=%h", rd1, 64'd10);
        end
    endtask

    task automatic test_dual_port();
        do_write(5'd12, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        ra1 = 5'd12; ra2 = 5'd12;
        #1;
        n_tests++;
        if (rd1 !== 64'hFFFF_FFFF_FFFF_FFFF || rd2 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL dual_port rd1=%h rd2=%h expected all ones", rd1, rd2);
        end
    endtask

    task automatic test_same_cycle();
        logic [63:0] exp_pre;
        @(negedge clk);
        ra1 = 5'd20; wa3 = 5'd20; we3 = 1'b1; wd3 = 64'h55;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 64'h55;
`else
        exp_pre = 64'd20;
`endif
        #1;
        n_tests++;
        if (rd1 !== exp_pre) begin
            n_fail++;
            $display("FAIL same_cycle_pre rd1=%h expected=%h", rd1, exp_pre);
        end
        @(posedge clk);
        model[20] = 64'h55;
        #1;
        n_tests++;
        if (rd1 !== 64'h55) begin
            n_fail++;
            $display("FAIL same_cycle_post rd1=%h expected=%h", rd1, 64'h55);
        end
        @(negedge clk);
        we3 = 1'b0;
        // XZR is never forwarded, even with a pending write to it.
        ra1 = 5'd31; wa3 = 5'd31; we3 = 1'b1; wd3 = 64'h1234;
        #1;
        n_tests++;
        if (rd1 !== 64'd0) begin
            n_fail++;
            $display("FAIL xzr_no_forward rd1=%h expected=0", rd1);
        end
        @(negedge clk);
        we3 = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            we3 = 1'($urandom_range(0, 1));
            wa3 = 5'($urandom_range(0, 31));
            wd3 = {$urandom, $urandom};
            ra1 = ($urandom_range(0, 3) == 0) ? wa3 : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 3) == 0) ? wa3 : 5'($urandom_range(0, 31));
            #1;
            n_tests++;
            if (rd1 !== m_read_now(ra1) || rd2 !== m_read_now(ra2)) begin
                n_fail++;
                $display("FAIL random n=%0d ra1=%0d rd1=%h exp=%h ra2=%0d rd2=%h exp=%h",
                         n, ra1, rd1, m_read_now(ra1), ra2, rd2, m_read_now(ra2));
            end
            @(posedge clk);
            if (we3 && wa3 != 5'd31) model[wa3] = wd3;
        end
        @(negedge clk);
        we3 = 1'b0;
    endtask

    task automatic test_async_reset();
        do_write(5'd3, 64'hA5A5_0000_1111_2222, 1'b1);
        ra1 = 5'd3;
        #2;
        reset = 1'b1;
        // A write held pending across the reset window must have no effect.
        we3 = 1'b1; wa3 = 5'd3; wd3 = 64'hBAD0_BAD0_BAD0_BAD0;
        #1;
        n_tests++;
        if (rd1 !== 64'd3) begin
            n_fail++;
            $display("FAIL async_reset_immediate rd1=%h expected=%h", rd1, 64'd3);
        end
        model_reset();
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a); ra2 = 5'(a);
            #1;
            n_tests++;
            if (rd1 !== m_read(ra1) || rd2 !== m_read(ra2)) begin
                n_fail++;
                $display("FAIL async_reset_sweep idx=%0d rd1=%h rd2=%h expected=%h",
                         a, rd1, rd2, m_read(ra1));
            end
        end
        we3 = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        we3 = 1'b1; wa3 = 5'd9; wd3 = 64'h0123_4567_89AB_CDEF;
        @(posedge clk);
        model[9] = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        we3 = 1'b0; ra2 = 5'd9;
        #1;
        n_tests++;
        if (rd2 !== 64'h0123_4567_89AB_CDEF) begin
            n_fail++;
            $display("FAIL write_after_reset rd2=%h expected=%h", rd2, 64'h0123_4567_89AB_CDEF);
        end
    endtask

    initial begin
        reset = 1'b1; we3 = 1'b0;
        ra1 = '0; ra2 = '0; wa3 = '0; wd3 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        test_reset();
        test_write_all();
        test_write_disable();
        test_dual_port();
        test_same_cycle();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_regfile

`default_nettype wire
